// File: rtl/overlay_message_ctrl.sv
// Overlay message sequencer: picks which full-screen message is shown, drives its
// blink phase, freezes game logic while a message is up and pulses restart/next-level.
module overlay_message_ctrl #(
    parameter int LEVEL_FRAMES    = 120,
    parameter int BLINK_FRAMES    = 16,
    parameter int OVER_MIN_FRAMES = 60
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       gameOverReq,
    input  logic       levelDoneReq,
    input  logic       pauseKey,
    input  logic       continueKey,
    output logic [1:0] message,
    output logic       messageVisible,
    output logic       freezeGame,
    output logic       nextLevel,
    output logic       restartGame
);

    // Encoding matches the message select, so the state register is the message output.
    typedef enum logic [1:0] {
        PLAY  = 2'b00,
        LEVEL = 2'b01,
        OVER  = 2'b10,
        PAUSE = 2'b11
    } state_t;

    localparam logic [9:0] LEVEL_LAST = 10'(LEVEL_FRAMES - 1);
    localparam logic [9:0] BLINK_LAST = 10'(BLINK_FRAMES - 1);
    localparam logic [9:0] OVER_MIN   = 10'(OVER_MIN_FRAMES);

    state_t     state, state_next;
    logic [9:0] frame_cnt, frame_next;
    logic [9:0] blink_cnt, blink_next;
    logic       visible_next;
    logic       pause_q, cont_q;
    logic       pause_edge, cont_edge, changed;

    assign pause_edge = pauseKey & ~pause_q;
    assign cont_edge  = continueKey & ~cont_q;
    assign message    = state;

    always_comb begin
        state_next = state;
        case (state)
            PLAY: begin
                if (gameOverReq)       state_next = OVER;
                else if (levelDoneReq) state_next = LEVEL;
                else if (pause_edge)   state_next = PAUSE;
            end
            LEVEL: begin
                if (gameOverReq)                                   state_next = OVER;
                else if (startOfFrame && frame_cnt == LEVEL_LAST) state_next = PLAY;
            end
            PAUSE: begin
                if (pause_edge) state_next = PLAY;
            end
            OVER: begin
                if (cont_edge && frame_cnt == OVER_MIN) state_next = PLAY;
            end
            default: state_next = PLAY;
        endcase
    end

    always_comb begin
        changed      = (state_next != state);
        frame_next   = frame_cnt;
        blink_next   = blink_cnt;
        visible_next = messageVisible;
        if (changed) begin
            frame_next = '0;
            blink_next = '0;
        end else if (startOfFrame) begin
            if (state == OVER && frame_cnt >= OVER_MIN) frame_next = OVER_MIN;
            else                                        frame_next = frame_cnt + 10'd1;
            if (blink_cnt == BLINK_LAST) begin
                blink_next   = '0;
                visible_next = ~messageVisible;
            end else begin
                blink_next = blink_cnt + 10'd1;
            end
        end
        // Blinking only applies to PAUSE/OVER; other states force a fixed phase.
        case (state_next)
            PLAY:    visible_next = 1'b0;
            LEVEL:   visible_next = 1'b1;
            default: if (changed) visible_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state          <= PLAY;
            frame_cnt      <= '0;
            blink_cnt      <= '0;
            messageVisible <= 1'b0;
            freezeGame     <= 1'b0;
            nextLevel      <= 1'b0;
            restartGame    <= 1'b0;
            pause_q        <= 1'b1;
            cont_q         <= 1'b1;
        end else begin
            state          <= state_next;
            frame_cnt      <= frame_next;
            blink_cnt      <= blink_next;
            messageVisible <= visible_next;
            freezeGame     <= (state_next != PLAY);
            nextLevel      <= (state == LEVEL) && (state_next == PLAY);
            restartGame    <= (state == OVER) && (state_next == PLAY);
            pause_q        <= pauseKey;
            cont_q         <= continueKey;
        end
    end

endmodule

// File: tb/tb_overlay_message_ctrl.sv
// Bench for overlay_message_ctrl: directed table, hand sequences and random stimulus
// against a frame-count reference model, on a default-ish and an all-ones parameter set.
module tb_overlay_message_ctrl;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic startOfFrame = 1'b0, gameOverReq = 1'b0, levelDoneReq = 1'b0;
    logic pauseKey = 1'b0, continueKey = 1'b0;

    logic [1:0] a_msg, b_msg;
    logic a_vis, a_frz, a_nl, a_rg;
    logic b_vis, b_frz, b_nl, b_rg;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    overlay_message_ctrl #(.LEVEL_FRAMES(4), .BLINK_FRAMES(2), .OVER_MIN_FRAMES(60)) dut_a (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .gameOverReq(gameOverReq),
        .levelDoneReq(levelDoneReq), .pauseKey(pauseKey), .continueKey(continueKey),
        .message(a_msg), .messageVisible(a_vis), .freezeGame(a_frz),
        .nextLevel(a_nl), .restartGame(a_rg));

    overlay_message_ctrl #(.LEVEL_FRAMES(1), .BLINK_FRAMES(1), .OVER_MIN_FRAMES(1)) dut_b (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .gameOverReq(gameOverReq),
        .levelDoneReq(levelDoneReq), .pauseKey(pauseKey), .continueKey(continueKey),
        .message(b_msg), .messageVisible(b_vis), .freezeGame(b_frz),
        .nextLevel(b_nl), .restartGame(b_rg));

    // Reference model: mode uses the message code, frames counts startOfFrame since entry.
    typedef struct {
        int mode;
        int frames;
        bit vis;
        bit pkp;
        bit ckp;
        bit nl;
        bit rg;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mreset();
        mdl_t r;
        r.mode = 0; r.frames = 0; r.vis = 0; r.pkp = 1; r.ckp = 1; r.nl = 0; r.rg = 0;
        return r;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit sof, bit go, bit ld, bit pk, bit ck,
                                   int lf, int bf, int om);
        mdl_t r = m;
        int nm = m.mode;
        bit pe = pk && !m.pkp;
        bit ce = ck && !m.ckp;
        case (m.mode)
            0: if (go) nm = 2; else if (ld) nm = 1; else if (pe) nm = 3;
            1: if (go) nm = 2; else if (sof && m.frames + 1 == lf) nm = 0;
            3: if (pe) nm = 0;
            default: if (ce && m.frames >= om) nm = 0;
        endcase
        r.nl = (m.mode == 1) && (nm == 0);
        r.rg = (m.mode == 2) && (nm == 0);
        if (nm != m.mode) r.frames = 0;
        else if (sof)     r.frames = m.frames + 1;
        r.mode = nm;
        r.pkp = pk;
        r.ckp = ck;
        if (nm == 0)      r.vis = 0;
        else if (nm == 1) r.vis = 1;
        else              r.vis = ((r.frames / bf) % 2) == 0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_models();
        chk("a_model_msg", 32'(a_msg), 32'(ma.mode));
        chk("a_model_vis", 32'(a_vis), 32'(ma.vis));
        chk("a_model_frz", 32'(a_frz), 32'(ma.mode != 0));
        chk("a_model_nl",  32'(a_nl),  32'(ma.nl));
        chk("a_model_rg",  32'(a_rg),  32'(ma.rg));
        chk("b_model_msg", 32'(b_msg), 32'(mb.mode));
        chk("b_model_vis", 32'(b_vis), 32'(mb.vis));
        chk("b_model_frz", 32'(b_frz), 32'(mb.mode != 0));
        chk("b_model_nl",  32'(b_nl),  32'(mb.nl));
        chk("b_model_rg",  32'(b_rg),  32'(mb.rg));
    endtask

    task automatic tick(input bit sof, input bit go, input bit ld, input bit pk, input bit ck);
        startOfFrame = sof; gameOverReq = go; levelDoneReq = ld; pauseKey = pk; continueKey = ck;
        @(posedge clk);
        ma = mstep(ma, sof, go, ld, pk, ck, 4, 2, 60);
        mb = mstep(mb, sof, go, ld, pk, ck, 1, 1, 1);
        #1;
        chk_models();
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_msg"}, 32'(a_msg), 0);
        chk({tag, "_vis"}, 32'(a_vis), 0);
        chk({tag, "_frz"}, 32'(a_frz), 0);
        chk({tag, "_nl"},  32'(a_nl),  0);
        chk({tag, "_rg"},  32'(a_rg),  0);
        chk({tag, "_b_msg"}, 32'(b_msg), 0);
        chk({tag, "_b_rg"},  32'(b_rg),  0);
    endtask

    typedef struct {
        bit sof, go, ld, pk, ck;
        logic [1:0] msg;
        bit vis, frz, nl, rg;
    } vec_t;

    vec_t tbl[17];

    initial begin
        // Directed table for dut_a (LEVEL_FRAMES=4, BLINK_FRAMES=2, OVER_MIN_FRAMES=60).
        //            sof go ld pk ck  msg   vis frz nl rg
        tbl[0]  = '{0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0};  // key held through reset: no edge
        tbl[1]  = '{0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 1, 0, 2'd3, 1, 1, 0, 0};  // pause
        tbl[3]  = '{1, 0, 0, 1, 0, 2'd3, 1, 1, 0, 0};
        tbl[4]  = '{1, 1, 0, 0, 0, 2'd3, 0, 1, 0, 0};  // gameOver ignored while paused
        tbl[5]  = '{1, 0, 0, 0, 0, 2'd3, 0, 1, 0, 0};
        tbl[6]  = '{1, 0, 0, 0, 0, 2'd3, 1, 1, 0, 0};
        tbl[7]  = '{0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0};  // unpause
        tbl[8]  = '{0, 0, 1, 0, 0, 2'd1, 1, 1, 0, 0};  // level done
        tbl[9]  = '{1, 0, 0, 0, 0, 2'd1, 1, 1, 0, 0};
        tbl[10] = '{1, 0, 0, 1, 0, 2'd1, 1, 1, 0, 0};  // pause edge ignored in LEVEL
        tbl[11] = '{1, 0, 0, 0, 0, 2'd1, 1, 1, 0, 0};
        tbl[12] = '{1, 0, 0, 0, 0, 2'd0, 0, 0, 1, 0};  // 4th frame: nextLevel
        tbl[13] = '{0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0};
        tbl[14] = '{0, 1, 1, 0, 0, 2'd2, 1, 1, 0, 0};  // gameOver beats levelDone
        tbl[15] = '{0, 0, 0, 0, 1, 2'd2, 1, 1, 0, 0};  // continue too early
        tbl[16] = '{0, 0, 0, 0, 0, 2'd2, 1, 1, 0, 0};

        resetN = 1'b0;
        pauseKey = 1'b1;
        ma = mreset();
        mb = mreset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_a("reset");
        @(negedge clk);
        resetN = 1'b1;

        for (int i = 0; i < 17; i++) begin
            tick(tbl[i].sof, tbl[i].go, tbl[i].ld, tbl[i].pk, tbl[i].ck);
            chk($sformatf("tbl%0d_msg", i), 32'(a_msg), 32'(tbl[i].msg));
            chk($sformatf("tbl%0d_vis", i), 32'(a_vis), 32'(tbl[i].vis));
            chk($sformatf("tbl%0d_frz", i), 32'(a_frz), 32'(tbl[i].frz));
            chk($sformatf("tbl%0d_nl", i),  32'(a_nl),  32'(tbl[i].nl));
            chk($sformatf("tbl%0d_rg", i),  32'(a_rg),  32'(tbl[i].rg));
        end

        // Asynchronous reset in the middle of OVER.
        repeat (5) tick(1, 0, 0, 0, 0);
        #2;
        resetN = 1'b0;
        #1;
        chk_reset_a("async_reset");
        @(posedge clk);
        #1;
        chk_reset_a("async_reset_hold");
        @(negedge clk);
        resetN = 1'b1;
        ma = mreset();
        mb = mreset();
        tick(0, 0, 0, 0, 0);
        chk("post_reset_rg", 32'(a_rg), 0);

        // LEVEL interrupted by gameOver at frame 3, then OVER continue window.
        tick(0, 0, 1, 0, 0);
        chk("lvl_entry_msg", 32'(a_msg), 1);
        repeat (3) tick(1, 0, 0, 0, 0);
        chk("lvl_f3_msg", 32'(a_msg), 1);
        tick(0, 1, 0, 0, 0);
        chk("lvl_over_msg", 32'(a_msg), 2);
        chk("lvl_over_vis", 32'(a_vis), 1);
        chk("lvl_over_nl", 32'(a_nl), 0);
        tick(1, 0, 0, 0, 0);
        chk("over_f1_vis", 32'(a_vis), 1);
        tick(1, 0, 0, 0, 0);
        chk("over_f2_vis", 32'(a_vis), 0);
        repeat (28) tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1);
        chk("over_f30_cont_msg", 32'(a_msg), 2);
        chk("over_f30_cont_rg", 32'(a_rg), 0);
        tick(0, 0, 0, 0, 0);
        repeat (29) tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1);
        chk("over_f59_cont_msg", 32'(a_msg), 2);
        tick(0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1);
        chk("over_f60_cont_msg", 32'(a_msg), 0);
        chk("over_f60_cont_rg", 32'(a_rg), 1);
        chk("over_f60_cont_frz", 32'(a_frz), 0);
        tick(0, 0, 0, 0, 0);
        chk("over_rg_one_clk", 32'(a_rg), 0);

        // Randomized traffic checked cycle by cycle against the model.
        begin
            bit pk = 1'b0;
            bit ck = 1'b0;
            for (int c = 0; c < 6000; c++) begin
                if ($urandom_range(9) == 0) pk = ~pk;
                if ($urandom_range(7) == 0) ck = ~ck;
                tick($urandom_range(3) == 0, $urandom_range(59) == 0,
                     $urandom_range(29) == 0, pk, ck);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
